// File: rtl/mua_pkg.sv
// Shared widths, FSM state type and a saturating-increment helper for the MUA serial scheduler.
package mua_pkg;
    localparam int LANE_W  = 32;
    localparam int CH_W    = 12;
    localparam int FRAME_W = 32;
    localparam int DROP_W  = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
        return (v == {DROP_W{1'b1}}) ? v : v + {{(DROP_W-1){1'b0}}, 1'b1};
    endfunction
endpackage

// File: rtl/mua_frame_tracker.sv
// Frame counter: bumps on a handshake of the last channel; clr wins over a simultaneous bump.
module mua_frame_tracker
    import mua_pkg::*;
#(
    parameter int NUM_CH = 160
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               fire,
    input  logic [CH_W-1:0]    ch,
    output logic [FRAME_W-1:0] frame_no
);
    logic [FRAME_W-1:0] frame_r;

    // Frame number register, wraps naturally at 2^FRAME_W
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_r <= {FRAME_W{1'b0}};
        end else if (clr) begin
            frame_r <= {FRAME_W{1'b0}};
        end else if (fire && (ch == CH_W'(NUM_CH - 1))) begin
            frame_r <= frame_r + {{(FRAME_W-1){1'b0}}, 1'b1};
        end else begin
            frame_r <= frame_r;
        end
    end

    assign frame_no = frame_r;
endmodule

// File: rtl/mua_serial_scheduler.sv
// Serialises LANES-wide beats into one lane-aligned word per cycle.
// Optional MUA_DROP_CNT_EN adds a saturating counter of refused input beats.
module mua_serial_scheduler
    import mua_pkg::*;
#(
    parameter int NUM_CH = 160,
    parameter int LANES  = 5
) (
    input  logic                    bus_clk,
    input  logic                    xike_reset_n,
    input  logic                    frame_count_rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [CH_W*LANES-1:0]   in_ch,
    input  logic [LANE_W*LANES-1:0] in_data,
    input  logic [LANE_W*LANES-1:0] in_thr,
    input  logic [LANE_W*LANES-1:0] in_hash,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [CH_W-1:0]         out_ch,
    output logic [LANE_W-1:0]       out_data,
    output logic [LANE_W-1:0]       out_thr,
    output logic [LANE_W-1:0]       out_hash,
    output logic [FRAME_W-1:0]      out_frame_no,
    output logic [DROP_W-1:0]       drop_cnt
);
    localparam int LANE_IW = (LANES > 1) ? $clog2(LANES) : 1;

    state_t                    state_r;
    logic [LANE_IW-1:0]        lane_r;
    logic                      out_valid_r;
    logic [CH_W*LANES-1:0]     shadow_ch_r;
    logic [LANE_W*LANES-1:0]   shadow_data_r;
    logic [LANE_W*LANES-1:0]   shadow_thr_r;
    logic [LANE_W*LANES-1:0]   shadow_hash_r;

    logic handshake_s;
    logic last_lane_s;
    logic in_ready_s;
    logic accept_s;

    assign handshake_s = out_valid_r & out_ready;
    assign last_lane_s = (lane_r == LANE_IW'(LANES - 1));
    assign in_ready_s  = (state_r == IDLE) | (last_lane_s & handshake_s);
    assign accept_s    = in_valid & in_ready_s;

    // Lane sequencer: a new beat can be loaded in the same cycle the last lane leaves
    always_ff @(posedge bus_clk) begin
        if (!xike_reset_n) begin
            state_r     <= IDLE;
            lane_r      <= {LANE_IW{1'b0}};
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        state_r     <= SHIFT;
                        lane_r      <= {LANE_IW{1'b0}};
                        out_valid_r <= 1'b1;
                    end else begin
                        state_r     <= IDLE;
                        lane_r      <= {LANE_IW{1'b0}};
                        out_valid_r <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (handshake_s && last_lane_s) begin
                        state_r     <= accept_s ? SHIFT : IDLE;
                        lane_r      <= {LANE_IW{1'b0}};
                        out_valid_r <= accept_s;
                    end else if (handshake_s) begin
                        state_r     <= SHIFT;
                        lane_r      <= lane_r + {{(LANE_IW-1){1'b0}}, 1'b1};
                        out_valid_r <= 1'b1;
                    end else begin
                        state_r     <= SHIFT;
                        lane_r      <= lane_r;
                        out_valid_r <= out_valid_r;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    lane_r      <= {LANE_IW{1'b0}};
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    // One shadow set for all four fields keeps every lane word skew-free
    always_ff @(posedge bus_clk) begin
        if (!xike_reset_n) begin
            shadow_ch_r   <= {(CH_W*LANES){1'b0}};
            shadow_data_r <= {(LANE_W*LANES){1'b0}};
            shadow_thr_r  <= {(LANE_W*LANES){1'b0}};
            shadow_hash_r <= {(LANE_W*LANES){1'b0}};
        end else if (accept_s) begin
            shadow_ch_r   <= in_ch;
            shadow_data_r <= in_data;
            shadow_thr_r  <= in_thr;
            shadow_hash_r <= in_hash;
        end else begin
            shadow_ch_r   <= shadow_ch_r;
            shadow_data_r <= shadow_data_r;
            shadow_thr_r  <= shadow_thr_r;
            shadow_hash_r <= shadow_hash_r;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign out_ch    = shadow_ch_r[CH_W*lane_r +: CH_W];
    assign out_data  = shadow_data_r[LANE_W*lane_r +: LANE_W];
    assign out_thr   = shadow_thr_r[LANE_W*lane_r +: LANE_W];
    assign out_hash  = shadow_hash_r[LANE_W*lane_r +: LANE_W];

    mua_frame_tracker #(
        .NUM_CH (NUM_CH)
    ) u_frame_tracker (
        .clk      (bus_clk),
        .rst_n    (xike_reset_n),
        .clr      (frame_count_rst),
        .fire     (handshake_s),
        .ch       (out_ch),
        .frame_no (out_frame_no)
    );

`ifdef MUA_DROP_CNT_EN
    logic              drop_s;
    logic [DROP_W-1:0] drop_cnt_r;

    assign drop_s = in_valid & ~in_ready_s;

    // Refused-beat counter, saturating
    always_ff @(posedge bus_clk) begin
        if (!xike_reset_n) begin
            drop_cnt_r <= {DROP_W{1'b0}};
        end else if (drop_s) begin
            drop_cnt_r <= sat_inc(drop_cnt_r);
        end else begin
            drop_cnt_r <= drop_cnt_r;
        end
    end

    assign drop_cnt = drop_cnt_r;
`else
    assign drop_cnt = {DROP_W{1'b0}};
`endif
endmodule

// File: tb/tb_mua_serial_scheduler.sv
// Directed scoreboard bench for mua_serial_scheduler (LANES=5, NUM_CH=160).
module tb_mua_serial_scheduler;
    localparam int LANES  = 5;
    localparam int NUM_CH = 160;

    logic                bus_clk = 1'b0;
    logic                xike_reset_n = 1'b0;
    logic                frame_count_rst = 1'b0;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic [12*LANES-1:0] in_ch = '0;
    logic [32*LANES-1:0] in_data = '0;
    logic [32*LANES-1:0] in_thr = '0;
    logic [32*LANES-1:0] in_hash = '0;
    logic                out_valid;
    logic                out_ready = 1'b1;
    logic [11:0]         out_ch;
    logic [31:0]         out_data;
    logic [31:0]         out_thr;
    logic [31:0]         out_hash;
    logic [31:0]         out_frame_no;
    logic [15:0]         drop_cnt;

    typedef struct packed {
        logic [11:0] ch;
        logic [31:0] data;
        logic [31:0] thr;
        logic [31:0] hash;
    } word_t;

    word_t       exp_q[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          acc_cyc = 0;
    logic [31:0] exp_frame = 32'd0;

    mua_serial_scheduler #(.NUM_CH(NUM_CH), .LANES(LANES)) dut (
        .bus_clk         (bus_clk),
        .xike_reset_n    (xike_reset_n),
        .frame_count_rst (frame_count_rst),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_ch           (in_ch),
        .in_data         (in_data),
        .in_thr          (in_thr),
        .in_hash         (in_hash),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_ch          (out_ch),
        .out_data        (out_data),
        .out_thr         (out_thr),
        .out_hash        (out_hash),
        .out_frame_no    (out_frame_no),
        .drop_cnt        (drop_cnt)
    );

    always #5 bus_clk = ~bus_clk;

    always @(posedge bus_clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Scoreboard: pop one expected word per handshake, model the frame number alongside
    always @(negedge bus_clk) begin
        word_t w;
        logic  hit_last;
        hit_last = 1'b0;
        if (xike_reset_n && out_valid && out_ready) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_word: observed ch=%0d data=0x%08h expected no word", out_ch, out_data);
            end
            if (exp_q.size() != 0) begin
                w = exp_q.pop_front();
                chk("out_ch", {20'd0, out_ch}, {20'd0, w.ch});
                chk("out_data", out_data, w.data);
                chk("out_thr", out_thr, w.thr);
                chk("out_hash", out_hash, w.hash);
                chk("out_frame_no", out_frame_no, exp_frame);
                hit_last = (w.ch == 12'(NUM_CH - 1));
            end
        end
        if (!xike_reset_n || frame_count_rst) exp_frame = 32'd0;
        else if (hit_last) exp_frame = exp_frame + 32'd1;
    end

    task automatic offer(input logic [11:0] cbase, input logic [31:0] dbase, input bit keep);
        bit    got;
        word_t w;
        for (int k = 0; k < LANES; k++) begin
            in_ch[12*k +: 12]   = cbase + 12'(k);
            in_data[32*k +: 32] = dbase + 32'(k);
            in_thr[32*k +: 32]  = 32'h7000_0000 | (dbase + 32'(k));
            in_hash[32*k +: 32] = ~(dbase + 32'(k));
        end
        in_valid = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge bus_clk);
            if (in_ready) got = 1'b1;
        end
        checks++;
        assert (got) else begin
            errors++;
            $error("FAIL accept_timeout: observed in_ready=0 expected 1 within 50 cycles");
        end
        if (got) begin
            acc_cyc = cyc;
            for (int k = 0; k < LANES; k++) begin
                w.ch   = cbase + 12'(k);
                w.data = dbase + 32'(k);
                w.thr  = 32'h7000_0000 | (dbase + 32'(k));
                w.hash = ~(dbase + 32'(k));
                exp_q.push_back(w);
            end
        end
        @(posedge bus_clk); #1;
        if (!keep) in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge bus_clk);
            if (!out_valid && exp_q.size() == 0) done = 1'b1;
        end
        checks++;
        assert (done) else begin
            errors++;
            $error("FAIL drain_timeout: observed pending=%0d expected 0", exp_q.size());
        end
        @(posedge bus_clk); #1;
    endtask

    initial begin
        int a0, a1, a2;

        // Reset state
        repeat (2) @(posedge bus_clk);
        #1;
        @(negedge bus_clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_frame_no", out_frame_no, 32'd0);
        chk("rst_drop_cnt", {16'd0, drop_cnt}, 32'd0);
        @(posedge bus_clk); #1;
        xike_reset_n = 1'b1;
        @(negedge bus_clk);
        chk("in_ready_after_rst", {31'd0, in_ready}, 32'd1);
        @(posedge bus_clk); #1;

        // Single beat, lanes 0..4
        offer(12'd0, 32'h100, 1'b0);
        chk("latency1_out_valid", {31'd0, out_valid}, 32'd1);
        wait_idle();

        // Stall at lane 2 with one refused beat during the stall
        offer(12'd20, 32'h200, 1'b0);
        @(posedge bus_clk); #1;
        @(posedge bus_clk); #1;
        out_ready = 1'b0;
        in_data   = {LANES{32'hDEAD_BEEF}};
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge bus_clk);
            chk("stall_ch", {20'd0, out_ch}, 32'd22);
            chk("stall_data", out_data, 32'h202);
            chk("stall_valid", {31'd0, out_valid}, 32'd1);
            @(posedge bus_clk); #1;
            in_valid = 1'b0;
        end
        out_ready = 1'b1;
        wait_idle();
`ifdef MUA_DROP_CNT_EN
        chk("drop_cnt_stall", {16'd0, drop_cnt}, 32'd1);
`else
        chk("drop_cnt_stall", {16'd0, drop_cnt}, 32'd0);
`endif

        // Back-to-back beats with in_valid held: acceptances exactly LANES apart
        offer(12'd50, 32'h300, 1'b1);
        a0 = acc_cyc;
        offer(12'd55, 32'h310, 1'b1);
        a1 = acc_cyc;
        offer(12'd60, 32'h320, 1'b0);
        a2 = acc_cyc;
        chk("b2b_gap1", 32'(a1 - a0), 32'd5);
        chk("b2b_gap2", 32'(a2 - a1), 32'd5);
        wait_idle();

        // Full frame sweep: one increment after ch 159
        for (int b = 0; b < 32; b++) offer(12'(5*b), 32'h1000 + 32'(8*b), b != 31);
        wait_idle();
        chk("frame_after_sweep", out_frame_no, 32'd1);

        // Second sweep with clear coinciding with the ch-159 handshake
        for (int b = 0; b < 32; b++) offer(12'(5*b), 32'h2000 + 32'(8*b), b != 31);
        repeat (4) begin
            @(posedge bus_clk); #1;
        end
        frame_count_rst = 1'b1;
        @(posedge bus_clk); #1;
        frame_count_rst = 1'b0;
        wait_idle();
        chk("frame_clear_priority", out_frame_no, 32'd0);

        // Reset while lane 3 is on the output
        offer(12'd40, 32'h400, 1'b0);
        repeat (3) begin
            @(posedge bus_clk); #1;
        end
        xike_reset_n = 1'b0;
        @(posedge bus_clk); #1;
        exp_q.delete();
        @(negedge bus_clk);
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_out_ch", {20'd0, out_ch}, 32'd0);
        chk("midrst_out_data", out_data, 32'd0);
        chk("midrst_out_thr", out_thr, 32'd0);
        chk("midrst_out_hash", out_hash, 32'd0);
        chk("midrst_drop_cnt", {16'd0, drop_cnt}, 32'd0);
        @(posedge bus_clk); #1;
        xike_reset_n = 1'b1;
        @(negedge bus_clk);
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        for (int i = 0; i < 8; i++) begin
            @(negedge bus_clk);
            chk("no_partial_word", {31'd0, out_valid}, 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mua_serial_scheduler.md
MUA_SERIAL_SCHEDULER -- requirements
Module: mua_serial_scheduler

Interface
REQ-001 SHALL have parameter NUM_CH, default 160, channels per frame.
REQ-002 SHALL have parameter LANES, default 5, 32-bit lanes per wide beat.
REQ-003 SHALL have port bus_clk, input, 1, the only clock.
REQ-004 SHALL have port xike_reset_n, input, 1, reset; synchronous, active-low.
REQ-005 SHALL have port frame_count_rst, input, 1, synchronous frame-number clear.
REQ-006 SHALL have port in_valid, input, 1, wide beat present.
REQ-007 SHALL have port in_ready, output, 1, wide beat accepted when high with in_valid.
REQ-008 SHALL have port in_ch, input, 12*LANES, per-lane channel IDs.
REQ-009 SHALL have ports in_data, in_thr and in_hash, input, 32*LANES each; per-lane data, threshold and channel hash.
REQ-010 SHALL have port out_valid, output, 1, serial word valid.
REQ-011 SHALL have port out_ready, input, 1, downstream ready; driven as !fifo_mua_full.
REQ-012 SHALL have ports out_ch (12), out_data (32), out_thr (32) and out_hash (32), output; lane-aligned serial fields.
REQ-013 SHALL have port out_frame_no, output, 32, frame number of the current word.
REQ-014 SHALL have port drop_cnt, output, 16, input beats refused.

Function
REQ-015 SHALL implement an FSM with states IDLE and SHIFT.
- IDLE -> SHIFT on in_valid.
- SHIFT -> IDLE on last-lane handshake without in_valid.
- SHIFT stays in SHIFT on last-lane handshake with in_valid (back-to-back load).
REQ-016 in_ready SHALL equal (state==IDLE) | (lane==LANES-1 & out_valid & out_ready).
REQ-017 On acceptance, SHALL register all four wide fields into one shadow set and set lane=0.
REQ-018 out_valid SHALL assert the cycle after acceptance (latency 1) and stay high through SHIFT.
REQ-019 Lane k SHALL drive bits [32k+31:32k] of data/thr/hash and [12k+11:12k] of ch, all from the same shadow beat (no field skew).
REQ-020 lane SHALL advance only on out_valid & out_ready; outputs SHALL hold stable while out_ready is low.
REQ-021 Sustained throughput SHALL be one word per cycle with out_ready high, i.e. one wide beat per LANES cycles.
REQ-022 out_frame_no SHALL increment by 1 on a handshake where out_ch==NUM_CH-1, wrapping 2^32-1 -> 0.
REQ-023 frame_count_rst SHALL clear out_frame_no to 0 next cycle and take priority over a simultaneous increment.
REQ-024 in_valid while in_ready is low SHALL be a drop: the beat is discarded and drop_cnt increments, saturating at 0xFFFF.

Reset
REQ-025 xike_reset_n low at a clock edge SHALL force: state=IDLE, lane=0, out_valid=0, out_frame_no=0, drop_cnt=0, shadow fields=0.
REQ-026 Reset mid-beat SHALL discard remaining lanes; no partial word SHALL emit after reset release.
REQ-027 in_ready SHALL be 1 in the first cycle after reset release.

Configuration
REQ-028 Macro MUA_DROP_CNT_EN defined: drop_cnt logic per REQ-024 SHALL be present.
REQ-029 Macro MUA_DROP_CNT_EN undefined: drop_cnt SHALL be tied to 0 with no counter flops; drops still discard silently.

Structure
REQ-030 Package mua_pkg SHALL hold LANE_W=32, CH_W=12, FRAME_W=32, DROP_W=16 and the state enum typedef (IDLE, SHIFT).
REQ-031 Frame numbering (REQ-022/023) SHALL be a sub-module mua_frame_tracker with ports clk, rst_n, clr, fire, ch, frame_no.

Verification
REQ-032 Single beat, ch={4,3,2,1,0}, data lane k=0x100+k, out_ready=1 -> 5 consecutive words ch 0..4, data 0x100..0x104, thr/hash aligned, then out_valid=0.
REQ-033 Back-to-back beats with in_valid held, out_ready=1 -> 10 contiguous words, in_ready pulses on cycles 5 and 10, no bubble.
REQ-034 out_ready low for 3 cycles at lane 2 -> lane 2 word held stable, then lanes 2..4 emit, and one in_valid pulse during the stall gives drop_cnt=1 (0 without MUA_DROP_CNT_EN).
REQ-035 32 beats covering ch 0..159 -> out_frame_no increments exactly once after ch 159; frame_count_rst asserted with the ch-159 handshake -> out_frame_no=0.
REQ-036 xike_reset_n low at lane 3 -> all outputs zero next cycle, in_ready=1 after release, no lane 4 word emitted.
